key_click_decoder: RTL

Downstream consumer of the key debouncer's confirmed-press pulse. Groups presses that arrive within a gap window into one click event: single, double or triple. Emits the event as a one-cycle `click_valid` strobe with a held `click_count`. Sits between the debounced key interface and application logic such as mode toggles or menu navigation.

---
 rtl/key_pkg.sv | 12 +
 rtl/key_click_if.sv | 10 +
 rtl/key_click_decoder.sv | 91 +++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key-input blocks: FSM state encoding and the
// gap-counter width reused across debouncer-side consumers.
package key_pkg;

    localparam int KEY_GAP_W = 24;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } key_state_e;

endpackage

// File: rtl/key_click_if.sv
// Debounced key press in, click events out. The decoder uses the slave side.
interface key_click_if;
    logic       press_in;
    logic       click_valid;
    logic [1:0] click_count;
    logic       busy;

    modport master (output press_in, input click_valid, click_count, busy);
    modport slave  (input press_in, output click_valid, click_count, busy);
endinterface

// File: rtl/key_click_decoder.sv
// Groups debounced presses separated by at most GAP_TIME idle cycles into a
// single/double/triple click event, strobed on click_valid.
module key_click_decoder
    import key_pkg::*;
#(
    parameter logic [KEY_GAP_W-1:0] GAP_TIME   = 24'd9_999_999,
    parameter logic [1:0]           MAX_CLICKS = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    key_click_if.slave  key
);

    key_state_e           state, state_n;
    logic [KEY_GAP_W-1:0] cnt_gap, cnt_gap_n;
    logic [1:0]           clicks, clicks_n;
    logic [1:0]           clicks_inc;
    logic                 emit;
    logic [1:0]           emit_count;
    logic                 click_valid_r;
    logic [1:0]           click_count_r;

    assign clicks_inc = clicks + 2'd1;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        clicks_n   = clicks;
        cnt_gap_n  = cnt_gap;
        emit       = 1'b0;
        emit_count = clicks;

        case (state)
            ST_IDLE: begin
                cnt_gap_n = '0;
                if (key.press_in) begin
                    clicks_n = 2'd1;
                    state_n  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A press always wins over a coincident gap timeout.
                if (key.press_in) begin
                    cnt_gap_n = '0;
                    if (clicks_inc == MAX_CLICKS) begin
                        emit       = 1'b1;
                        emit_count = MAX_CLICKS;
                        clicks_n   = 2'd0;
                        state_n    = ST_IDLE;
                    end else begin
                        clicks_n = clicks_inc;
                    end
                end else if (cnt_gap == GAP_TIME) begin
                    emit      = 1'b1;
                    clicks_n  = 2'd0;
                    cnt_gap_n = '0;
                    state_n   = ST_IDLE;
                end else begin
                    cnt_gap_n = cnt_gap + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            clicks        <= 2'd0;
            cnt_gap       <= '0;
            click_valid_r <= 1'b0;
            click_count_r <= 2'd0;
        end else begin
            state         <= state_n;
            clicks        <= clicks_n;
            cnt_gap       <= cnt_gap_n;
            click_valid_r <= emit;
            if (emit) begin
                click_count_r <= emit_count;
            end
        end
    end

    assign key.click_valid = click_valid_r;
    assign key.click_count = click_count_r;
    assign key.busy        = (state == ST_WAIT);

endmodule
